// File: rtl/srl_pkg.sv
// rtl/srl_pkg.sv - shared constants and width helpers for the SRL32 FIFO slice
package srl_pkg;

   localparam int SRL_SEG_DEPTH = 32;
   localparam int SRL_ADDR_W    = 5;

   // Occupancy needs one bit more than the chain address so that "full" is representable.
   function automatic int srl_count_w(input int segs);
      return $clog2(SRL_SEG_DEPTH * segs) + 1;
   endfunction

   function automatic int srl_sel_w(input int segs);
      return (segs > 1) ? $clog2(segs) : 1;
   endfunction

endpackage

// File: rtl/srl_chain.sv
// rtl/srl_chain.sv - W-bit bank of cascaded SRL32 segments with segment output mux
module srl_chain
   import srl_pkg::*;
#(
   parameter int W    = 8,
   parameter int SEGS = 4,
   localparam int SEL_W = srl_sel_w(SEGS)
) (
   input  logic                  CLK,
   input  logic                  CE,
   input  logic [W-1:0]          D,
   input  logic [SRL_ADDR_W-1:0] A,
   input  logic [SEL_W-1:0]      SEL,
   output logic [W-1:0]          Q
);

   // Contents are never reset, exactly like the LUT shift registers they model.
   logic [W-1:0] seg [SEGS][SRL_SEG_DEPTH];

   always_ff @(posedge CLK) begin
      if (CE) begin
         for (int s = 0; s < SEGS; s++) begin
            seg[s][0] <= (s == 0) ? D : seg[(s == 0) ? 0 : s - 1][SRL_SEG_DEPTH-1];
            for (int i = 1; i < SRL_SEG_DEPTH; i++) begin
               seg[s][i] <= seg[s][i-1];
            end
         end
      end
   end

   generate
      if (SEGS > 1) begin : g_mux
         assign Q = seg[SEL][A];
      end else begin : g_single
         assign Q = seg[0][A];
      end
   endgenerate

endmodule

// File: rtl/srl_fifo_ctrl.sv
// rtl/srl_fifo_ctrl.sv - occupancy, address and handshake control for an SRL32-chain FIFO
module srl_fifo_ctrl
   import srl_pkg::*;
#(
   parameter int SEGS      = 4,
   parameter int AFULL_LVL = 96,
   localparam int CNT_W = srl_count_w(SEGS),
   localparam int SEL_W = srl_sel_w(SEGS)
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  S_VALID,
   output logic                  S_READY,
   output logic                  M_VALID,
   input  logic                  M_READY,
   output logic                  SRL_CE,
   output logic [SRL_ADDR_W-1:0] SRL_A,
   output logic [SEL_W-1:0]      SRL_SEL,
   output logic [CNT_W-1:0]      COUNT,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  AFULL
);

   localparam int PTR_W = CNT_W - 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(SRL_SEG_DEPTH * SEGS);
   localparam logic [CNT_W-1:0] AFULL_C   = CNT_W'(AFULL_LVL);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             rdy_q;
   logic             afull_q;
   logic             push, pop;

   assign FULL    = (cnt_q == DEPTH_C);
   assign EMPTY   = (cnt_q == '0);
   assign S_READY = rdy_q & ~FULL;
   assign M_VALID = ~EMPTY;
   assign push    = S_VALID & S_READY;
   assign pop     = M_VALID & M_READY;
   assign SRL_CE  = push;

   // ptr is kept as its own register so SRL_A/SRL_SEL come straight off flops.
   always_comb begin
      cnt_d = cnt_q;
      ptr_d = ptr_q;
      case ({push, pop})
         2'b10: begin
            cnt_d = cnt_q + CNT_ONE;
            ptr_d = EMPTY ? '0 : ptr_q + PTR_ONE;
         end
         2'b01: begin
            cnt_d = cnt_q - CNT_ONE;
            ptr_d = (cnt_q == CNT_ONE) ? '0 : ptr_q - PTR_ONE;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q   <= '0;
         ptr_q   <= '0;
         rdy_q   <= 1'b0;
         afull_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         rdy_q   <= 1'b1;
         afull_q <= (cnt_d >= AFULL_C);
      end
   end

   assign COUNT = cnt_q;
   assign AFULL = afull_q;
   assign SRL_A = ptr_q[SRL_ADDR_W-1:0];

   generate
      if (SEGS > 1) begin : g_sel
         assign SRL_SEL = ptr_q[PTR_W-1:SRL_ADDR_W];
      end else begin : g_nosel
         assign SRL_SEL = '0;
      end
   endgenerate

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb/tb_srl_fifo_ctrl.sv - scoreboard bench for srl_fifo_ctrl driving a behavioural SRL chain
module tb_srl_fifo_ctrl;

   localparam int SEGS  = 4;
   localparam int DEPTH = 32 * SEGS;
   localparam int AFL   = 96;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_valid;
   logic       s_ready;
   logic       m_valid;
   logic       m_ready;
   logic       srl_ce;
   logic [4:0] srl_a;
   logic [1:0] srl_sel;
   logic [7:0] count;
   logic       full, empty, afull;
   logic [7:0] s_data;
   logic [7:0] q;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q [$];
   int         m_cnt = 0;
   logic       m_rdy = 1'b0;

   always #5 clk = ~clk;

   srl_fifo_ctrl #(.SEGS(SEGS), .AFULL_LVL(AFL)) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .S_VALID (s_valid),
      .S_READY (s_ready),
      .M_VALID (m_valid),
      .M_READY (m_ready),
      .SRL_CE  (srl_ce),
      .SRL_A   (srl_a),
      .SRL_SEL (srl_sel),
      .COUNT   (count),
      .FULL    (full),
      .EMPTY   (empty),
      .AFULL   (afull)
   );

   srl_chain #(.W(8), .SEGS(SEGS)) u_chain (
      .CLK (clk),
      .CE  (srl_ce),
      .D   (s_data),
      .A   (srl_a),
      .SEL (srl_sel),
      .Q   (q)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model of the control state; pushes expected words on accepted writes.
   always @(negedge clk) begin
      logic exp_ready, exp_push, exp_pop;
      int   m_ptr;
      if (!rst_n) begin
         m_cnt = 0;
         m_rdy = 1'b0;
         exp_q.delete();
      end
      exp_ready = m_rdy && (m_cnt < DEPTH);
      exp_push  = s_valid && exp_ready;
      exp_pop   = (m_cnt != 0) && m_ready;
      m_ptr     = (m_cnt == 0) ? 0 : m_cnt - 1;
      check("count",   32'(count),   32'(m_cnt));
      check("empty",   32'(empty),   32'(m_cnt == 0));
      check("full",    32'(full),    32'(m_cnt == DEPTH));
      check("afull",   32'(afull),   32'(m_cnt >= AFL));
      check("s_ready", 32'(s_ready), 32'(exp_ready));
      check("m_valid", 32'(m_valid), 32'(m_cnt != 0));
      check("srl_ce",  32'(srl_ce),  32'(exp_push));
      check("srl_a",   32'(srl_a),   32'(m_ptr % 32));
      check("srl_sel", 32'(srl_sel), 32'(m_ptr / 32));
      if (exp_push) exp_q.push_back(s_data);
      m_cnt = m_cnt + int'(exp_push) - int'(exp_pop);
      m_rdy = rst_n;
   end

   // Monitor: every word handed to the reader must be the oldest one written.
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL q_underflow @%0t: got word %0h expected none", $time, q);
         end else begin
            check("q_data", 32'(q), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic drive(input logic rst, input logic sv, input logic [7:0] d, input logic mr);
      @(posedge clk);
      #1;
      rst_n   = rst;
      s_valid = sv;
      s_data  = d;
      m_ready = mr;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'hA5;
      m_ready = 1'b0;

      // reset with writer already offering 0xA5, then single word in/out
      repeat (3) drive(1'b0, 1'b1, 8'hA5, 1'b0);
      drive(1'b1, 1'b1, 8'hA5, 1'b0);
      drive(1'b1, 1'b1, 8'hA5, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      // fill to full, refused extra writes, full with simultaneous pop, drain
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 8'(i), 1'b0);
      repeat (2) drive(1'b1, 1'b1, 8'hFF, 1'b0);
      drive(1'b1, 1'b1, 8'hEE, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      // cross the first segment boundary, then drain in order
      for (int i = 0; i < 33; i++) drive(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 33; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      // steady push+pop at occupancy 50
      for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 200; i++) drive(1'b1, 1'b1, 8'($urandom), 1'b1);
      for (int i = 0; i < 50; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      // reset mid-operation discards contents; recovery pushes one word
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 8'(8'h90 + i), 1'b0);
      drive(1'b0, 1'b1, 8'h11, 1'b1);
      drive(1'b0, 1'b1, 8'h11, 1'b1);
      drive(1'b1, 1'b1, 8'h77, 1'b0);
      drive(1'b1, 1'b1, 8'h77, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      @(negedge clk);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
